// File: rtl/ternary_serial_minmax.sv
// rtl/ternary_serial_minmax.sv - serial MSB-first balanced-ternary word compare with packed min/max output
module ternary_serial_minmax #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [1:0]       a_trit,
    input  logic [1:0]       b_trit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   min_word,
    output logic [2*N-1:0]   max_word,
    output logic [1:0]       cmp,
    output logic             err
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);
    localparam logic [2*N-1:0] ZERO_WORD = {N{2'b01}};

    // State codes double as the cmp output encoding.
    typedef enum logic [1:0] {
        S_LT = 2'b00,
        S_EQ = 2'b01,
        S_GT = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_cmp_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_a;
    logic [2*N-1:0]  r_b;
    logic            r_sticky;
    logic            r_out_valid;
    logic [2*N-1:0]  r_min;
    logic [2*N-1:0]  r_max;
    logic [1:0]      r_cmp;
    logic            r_err;

    logic            w_accept;
    logic            w_a_ill;
    logic            w_b_ill;
    logic [1:0]      w_a_t;
    logic [1:0]      w_b_t;
    logic            w_last_trit;
    logic            w_word_end;
    logic            w_frame_err;
    logic [2*N-1:0]  w_a_buf;
    logic [2*N-1:0]  w_b_buf;

    assign in_ready    = !r_out_valid;
    assign out_valid   = r_out_valid;
    assign min_word    = r_min;
    assign max_word    = r_max;
    assign cmp         = r_cmp;
    assign err         = r_err;

    assign w_accept    = in_valid && !r_out_valid;
    assign w_a_ill     = (a_trit == 2'b11);
    assign w_b_ill     = (b_trit == 2'b11);
    assign w_a_t       = w_a_ill ? 2'b01 : a_trit;
    assign w_b_t       = w_b_ill ? 2'b01 : b_trit;
    assign w_last_trit = (r_cnt == CNT_MAX);
    assign w_word_end  = w_accept && (in_last || w_last_trit);
    assign w_frame_err = (in_last != w_last_trit);

    // Legal trit codes are monotonic in value, so a plain unsigned compare orders them.
    always_comb begin
        w_cmp_state  = r_state;
        if (w_accept && (r_state == S_EQ)) begin
            if (w_a_t < w_b_t) begin
                w_cmp_state = S_LT;
            end else if (w_a_t > w_b_t) begin
                w_cmp_state = S_GT;
            end
        end
        w_state_next = w_word_end ? S_EQ : w_cmp_state;
    end

    always_comb begin
        w_a_buf = (r_cnt == '0) ? ZERO_WORD : r_a;
        w_b_buf = (r_cnt == '0) ? ZERO_WORD : r_b;
        for (int i = 0; i < N; i++) begin
            if (i == (N - 1 - int'(r_cnt))) begin
                w_a_buf[2*i +: 2] = w_a_t;
                w_b_buf[2*i +: 2] = w_b_t;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_a         <= ZERO_WORD;
            r_b         <= ZERO_WORD;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_min       <= ZERO_WORD;
            r_max       <= ZERO_WORD;
            r_cmp       <= 2'b01;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= w_a_buf;
                r_b      <= w_b_buf;
                r_cnt    <= w_word_end ? '0 : r_cnt + 1'b1;
                r_sticky <= w_word_end ? 1'b0 : (r_sticky | w_a_ill | w_b_ill);
            end
            if (w_word_end) begin
                r_out_valid <= 1'b1;
                r_cmp       <= w_cmp_state;
                r_min       <= (w_cmp_state == S_GT) ? w_b_buf : w_a_buf;
                r_max       <= (w_cmp_state == S_GT) ? w_a_buf : w_b_buf;
                r_err       <= r_sticky | w_a_ill | w_b_ill | w_frame_err;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ternary_serial_minmax.sv
// tb/tb_ternary_serial_minmax.sv - directed and randomized checks of ternary_serial_minmax against a value-level model
module tb_ternary_serial_minmax;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_last = 1'b0;
    logic [1:0]       a_trit = 2'b01;
    logic [1:0]       b_trit = 2'b01;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2*N-1:0]   min_word;
    logic [2*N-1:0]   max_word;
    logic [1:0]       cmp;
    logic             err;

    ternary_serial_minmax #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a_trit(a_trit), .b_trit(b_trit),
        .out_valid(out_valid), .out_ready(out_ready),
        .min_word(min_word), .max_word(max_word), .cmp(cmp), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*N-1:0] mn;
        logic [2*N-1:0] mx;
        logic [1:0]     c;
        logic           e;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;
    bit   mon_on = 0;

    int   m_cnt = 0;
    int   m_a[N];
    int   m_b[N];
    bit   m_st = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Words are compared by their integer value: sum of (code-1)*3^i.
    function automatic void model_push(input logic [1:0] a, input logic [1:0] b, input logic last);
        int va, vb, p;
        res_t r;
        logic [2*N-1:0] pa, pb;
        if (m_cnt == 0) begin
            for (int i = 0; i < N; i++) begin m_a[i] = 1; m_b[i] = 1; end
            m_st = 0;
        end
        m_a[N-1-m_cnt] = (a == 2'b11) ? 1 : int'(a);
        m_b[N-1-m_cnt] = (b == 2'b11) ? 1 : int'(b);
        if (a == 2'b11 || b == 2'b11) m_st = 1;
        if (last || m_cnt == N-1) begin
            va = 0; vb = 0; p = 1;
            for (int i = 0; i < N; i++) begin
                va += (m_a[i] - 1) * p;
                vb += (m_b[i] - 1) * p;
                pa[2*i +: 2] = 2'(m_a[i]);
                pb[2*i +: 2] = 2'(m_b[i]);
                p *= 3;
            end
            r.c  = (va < vb) ? 2'b00 : (va == vb) ? 2'b01 : 2'b10;
            r.mn = (va <= vb) ? pa : pb;
            r.mx = (va <= vb) ? pb : pa;
            r.e  = m_st | (last != (m_cnt == N-1));
            exp_q.push_back(r);
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom % 3) != 0;
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (mon_on && rst_n) begin
            check("in_ready", in_ready, !out_valid);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", out_valid, 1'b0);
                end else begin
                    check("min_word", min_word, exp_q[0].mn);
                    check("max_word", max_word, exp_q[0].mx);
                    check("cmp", cmp, exp_q[0].c);
                    check("err", err, exp_q[0].e);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_pair(input logic [1:0] a, input logic [1:0] b, input logic last);
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a_trit = a; b_trit = b; in_last = last;
            if (in_ready) begin
                model_push(a, b, last);
                done = 1;
            end
        end
        if (!done) fail_now("send_pair");
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0; end
    endtask

    task automatic send_word(input logic [2*N-1:0] a, input logic [2*N-1:0] b, input int len, input logic use_last);
        for (int i = 0; i < len; i++)
            send_pair(a[2*(N-1-i) +: 2], b[2*(N-1-i) +: 2], use_last && (i == len-1));
        idle(1);
    endtask

    task automatic wait_result(input string tag, input logic [2*N-1:0] mn, input logic [2*N-1:0] mx,
                               input logic [1:0] c, input logic e);
        bit got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        if (!got) fail_now({tag, "_valid"});
        else begin
            check({tag, "_min"}, min_word, mn);
            check({tag, "_max"}, max_word, mx);
            check({tag, "_cmp"}, cmp, c);
            check({tag, "_err"}, err, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_min", min_word, {N{2'b01}});
        check("rst_max", max_word, {N{2'b01}});
        check("rst_cmp", cmp, 2'b01);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] ta, tb;
        res_t held;
        repeat (3) @(posedge clk);
        do_reset();
        mon_on = 1;

        send_word(8'b10010001, 8'b10010001, 4, 1);
        wait_result("eq", 8'b10010001, 8'b10010001, 2'b01, 1'b0);

        send_word(8'b00101010, 8'b01000000, 4, 1);
        wait_result("lt", 8'b00101010, 8'b01000000, 2'b00, 1'b0);
        send_word(8'b01000000, 8'b00101010, 4, 1);
        wait_result("gt", 8'b00101010, 8'b01000000, 2'b10, 1'b0);

        send_word(8'b10110101, 8'b10010101, 4, 1);
        wait_result("illegal", 8'b10010101, 8'b10010101, 2'b01, 1'b1);
        send_word(8'b10000101, 8'b10010101, 2, 1);
        wait_result("short", 8'b10000101, 8'b10010101, 2'b00, 1'b1);

        send_word(8'b10010001, 8'b10010001, 4, 0);
        wait_result("long", 8'b10010001, 8'b10010001, 2'b01, 1'b1);
        send_word(8'b10100000, 8'b10011010, 4, 1);
        wait_result("after_long", 8'b10011010, 8'b10100000, 2'b10, 1'b0);

        rdy_mode = 2;
        send_word(8'b00000000, 8'b10101010, 4, 1);
        wait_result("bp", 8'b00000000, 8'b10101010, 2'b00, 1'b0);
        held = {min_word, max_word, cmp, err};
        @(posedge clk); #1;
        in_valid = 1'b1; a_trit = 2'b10; b_trit = 2'b00; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready", in_ready, 1'b0);
            check("bp_hold", {min_word, max_word, cmp, err}, held);
        end
        rdy_mode = 0;
        send_word(8'b10101010, 8'b00101010, 4, 1);
        wait_result("bp_next", 8'b00101010, 8'b10101010, 2'b10, 1'b0);

        send_pair(2'b10, 2'b00, 1'b0);
        send_pair(2'b00, 2'b10, 1'b0);
        idle(1);
        do_reset();
        send_word(8'b00010110, 8'b00010110, 4, 1);
        wait_result("post_reset", 8'b00010110, 8'b00010110, 2'b01, 1'b0);

        rdy_mode = 2;
        send_word(8'b10101010, 8'b01010101, 4, 1);
        idle(2);
        do_reset();
        rdy_mode = 0;
        send_word(8'b01010100, 8'b01010110, 4, 1);
        wait_result("reset_pending", 8'b01010100, 8'b01010110, 2'b00, 1'b0);

        rdy_mode = 1;
        for (int i = 0; i < 600; i++) begin
            ta = (($urandom % 16) == 0) ? 2'b11 : 2'($urandom % 3);
            tb = (($urandom % 16) == 0) ? 2'b11 : 2'($urandom % 3);
            if (($urandom % 4) == 0) ta = tb;
            send_pair(ta, tb, (($urandom % 5) == 0));
            if (($urandom % 6) == 0) idle(1 + $urandom % 2);
        end
        idle(1);
        rdy_mode = 0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ternary_serial_minmax.md
Name: ternary_serial_minmax

Overview:
- Streaming front end for the ternary min/max datapath.
- Accepts two balanced-ternary words serially, one trit pair per cycle, MSB first.
- Resolves the word-level ordering with a small FSM and emits packed min word, max word and a ternary compare result.
- The packed words feed the word-wide ternary min/max stages directly downstream.
- Trit encoding throughout: 2'b00 = -, 2'b01 = 0, 2'b10 = +, 2'b11 = illegal.

Parameters:
- N, 4, trits per word. N >= 2. Packed word width is 2N bits; trit i occupies bits [2i+1:2i]; trit N-1 is the MSB.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous active-low reset.
- in_valid  in  1  Trit pair valid.
- in_ready  out  1  Block can accept a trit pair.
- in_last  in  1  Current pair is the word LSB (framing marker).
- a_trit  in  2  Trit of operand A.
- b_trit  in  2  Trit of operand B.
- out_valid  out  1  Result valid; held until accepted.
- out_ready  in  1  Downstream accepts the result.
- min_word  out  2N  Smaller word, packed.
- max_word  out  2N  Larger word, packed.
- cmp  out  2  Word ordering as a trit: 00 A<B, 01 A==B, 10 A>B.
- err  out  1  Illegal trit or framing error in this word.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, min_word and max_word all trits 01, cmp=01, err=0, cnt=0, FSM in EQ.
- Handshake:
  - A pair is accepted when in_valid && in_ready.
  - in_ready = !out_valid. There is no input acceptance in the cycle a result is popped.
  - A result is popped when out_valid && out_ready. out_valid falls on the next edge.
  - Outputs are stable while out_valid=1.
- Word storage:
  - A and B buffers are preset to all-01 when a word starts, i.e. cnt==0 on accept.
  - The accepted trit is written at index N-1-cnt, then cnt increments.
- Illegal input:
  - A code of 11 on either input is stored and compared as 01.
  - It sets the sticky word error flag.
- FSM, compare state (only trits accepted while in EQ affect it):
  - EQ: trit A<B goes to LT, A>B goes to GT, equal stays in EQ.
  - LT and GT are absorbing for the rest of the word.
- Word end: the word ends on the accepted pair where in_last=1 OR cnt==N-1, whichever comes first. On the next edge:
  - out_valid=1.
  - cmp = 00 (LT), 01 (EQ) or 10 (GT), using the compare state including the final trit.
  - min_word = A if LT or EQ, else B. max_word is the other word.
  - err = sticky flag OR framing error.
  - FSM returns to EQ, cnt=0, sticky flag cleared.
- Framing error:
  - in_last=1 with cnt<N-1 (short word): unreceived low trits remain 01.
  - cnt==N-1 with in_last=0 (long word): the word closes at N trits; following pairs start a new word.
- Latency: one cycle from the final accepted pair to out_valid.
- Throughput: N+1 cycles per word minimum when out_ready is tied high.
- in_valid low mid-word: state holds, no timeout.
- Reset asserted mid-word or while out_valid: everything clears immediately. The partial word and the pending result are discarded.

Test Plan:
1. Equal words (N=4): A=B=+0-0 (10 01 00 01), in_last on trit 4 -> one cycle later out_valid=1, cmp=01, min_word=max_word=8'b10010001, err=0.
2. MSB decides: A=-+++, B=0--- -> cmp=00, min_word=8'b00101010, max_word=8'b01000000. Also A=0---, B=-+++ -> cmp=10 with identical min_word/max_word, confirming the later trits are ignored once decided.
3. Backpressure: out_ready=0 for 5 cycles after result 1 while in_valid=1 -> in_ready=0, outputs constant. On the out_ready pulse, out_valid falls; the next word is accepted the following cycle and its result is correct.
4. Illegal/framing:
   - a_trit=11 at trit 2 of A=+?00 vs B=+000 -> A treated as +000, cmp=01, err=1.
   - in_last on trit 2 of A=+-, B=+0 -> cmp=00, min_word=8'b10000101, err=1.
5. Long word: 5 pairs without in_last -> word closes after 4 with err=1. The 5th pair becomes the MSB of the next word.
6. Reset mid-word: rst_n low asynchronously after trit 2 -> out_valid=0 immediately. The next full word compares correctly with no residue.
